// File: rtl/keypad_scan_debounce.sv
// 4x3 matrix keypad scanner: one-hot row drive, 2-flop column sync, frame-based
// debounce with multi-key rejection, one-cycle key_valid / multi_key strobes.
module keypad_scan_debounce #(
  parameter logic [27:0] clk_freq        = 28'd1000_0000,
  parameter logic [27:0] scan_rate       = 28'd250_0000,
  parameter int unsigned debounce_frames = 2
) (
  input  logic       sys_clk_in,
  input  logic       reset,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  output logic [3:0] pin_control,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int unsigned SCAN_DIV = 32'(clk_freq / scan_rate);
  localparam int unsigned PRE_W    = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W    = $clog2(debounce_frames + 1);
  localparam logic [CNT_W-1:0] DB  = CNT_W'(debounce_frames);

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_PRESSED, S_RELEASE} state_t;

  logic [2:0]       sync1_q, sync2_q;
  logic [PRE_W-1:0] pre_q;
  logic [1:0]       row_q;
  logic [11:0]      frame_q;
  logic             tick, frame_done;
  logic [11:0]      frame_cur;
  logic [3:0]       n_set, hit_idx, hit_key;
  logic             is_none, is_single, is_multi;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d, code_d;
  logic             held_d, valid_d, multi_d, accept;

  assign tick       = (pre_q == PRE_W'(SCAN_DIV - 1));
  assign frame_done = tick && (row_q == 2'd3);
  // The row-3 sample is classified live, before it lands in frame_q.
  assign frame_cur  = {sync2_q, frame_q[8:0]};

  // Column synchronizer, prescaler and row scan
  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pre_q       <= '0;
      row_q       <= '0;
      frame_q     <= '0;
      pin_control <= 4'b0001;
    end else begin
      sync1_q <= {G, F, E};
      sync2_q <= sync1_q;
      pre_q   <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        frame_q[4'(row_q) * 4'd3 +: 3] <= sync2_q;
        row_q       <= row_q + 2'd1;
        pin_control <= 4'b0001 << (row_q + 2'd1);
      end
    end
  end

  function automatic logic [3:0] map_key(input logic [3:0] idx);
    case (idx)
      4'd9:    map_key = 4'd10;
      4'd10:   map_key = 4'd0;
      4'd11:   map_key = 4'd11;
      default: map_key = idx + 4'd1;
    endcase
  endfunction

  // Frame classification: bit count and position of the (last) set bit
  always_comb begin
    n_set   = '0;
    hit_idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (frame_cur[i]) begin
        n_set   = n_set + 4'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign hit_key   = map_key(hit_idx);
  assign is_none   = (n_set == 4'd0);
  assign is_single = (n_set == 4'd1);
  assign is_multi  = (n_set >= 4'd2);

  // Debounce FSM next state and outputs, advanced only on frame_done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = key_code;
    held_d  = key_held;
    valid_d = 1'b0;
    multi_d = 1'b0;
    accept  = 1'b0;
    if (frame_done) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_single) begin
            cand_d  = hit_key;
            cnt_d   = CNT_W'(1);
            state_d = S_CONFIRM;
            if (cnt_d == DB) accept = 1'b1;
          end else if (is_multi) begin
            multi_d = 1'b1;
          end
        end
        S_CONFIRM: begin
          if (is_single && (hit_key == cand_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == DB) accept = 1'b1;
          end else begin
            multi_d = is_multi;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_PRESSED: begin
          if (is_none) begin
            cnt_d   = CNT_W'(1);
            state_d = S_RELEASE;
            if (cnt_d == DB) begin
              state_d = S_IDLE;
              held_d  = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        S_RELEASE: begin
          if (is_none) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == DB) begin
              state_d = S_IDLE;
              held_d  = 1'b0;
              cnt_d   = '0;
            end
          end else begin
            state_d = S_PRESSED;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (accept) begin
      code_d  = cand_d;
      valid_d = 1'b1;
      held_d  = 1'b1;
      cnt_d   = '0;
      state_d = S_PRESSED;
    end
  end

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cand_q    <= '0;
      key_code  <= '0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_code  <= code_d;
      key_held  <= held_d;
      key_valid <= valid_d;
      multi_key <= multi_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with a matrix column model driven
// by pin_control; default parameters give 4 cycles per row, 16 per frame.
module tb_keypad_scan_debounce;

  logic        sys_clk_in = 1'b0;
  logic        reset      = 1'b0;
  logic [11:0] pressed    = '0;
  logic        E, F, G;
  logic [3:0]  pin_control, key_code;
  logic        key_valid, key_held, multi_key;

  int n_checks  = 0;
  int n_fail    = 0;
  int valid_cnt = 0;
  int multi_cnt = 0;
  int both_cnt  = 0;
  int v0, m0;
  int key_idx[3]  = '{9, 10, 11};
  int key_code_exp[3] = '{10, 0, 11};

  keypad_scan_debounce dut (
    .sys_clk_in (sys_clk_in),
    .reset      (reset),
    .E          (E),
    .F          (F),
    .G          (G),
    .pin_control(pin_control),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .multi_key  (multi_key)
  );

  always #5 sys_clk_in = ~sys_clk_in;

  // Key index = row*3 + col; a column is high when its key sits on the driven row
  assign E = |(pin_control & {pressed[9],  pressed[6], pressed[3], pressed[0]});
  assign F = |(pin_control & {pressed[10], pressed[7], pressed[4], pressed[1]});
  assign G = |(pin_control & {pressed[11], pressed[8], pressed[5], pressed[2]});

  always @(negedge sys_clk_in) begin
    if (key_valid) valid_cnt <= valid_cnt + 1;
    if (multi_key) multi_cnt <= multi_cnt + 1;
    if (key_valid && multi_key) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk_in);
    #2;
  endtask

  // Return just after the edge that moves the scan from row 3 back to row 0
  task automatic align_frame;
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = pin_control;
    for (int i = 0; i < 40 && !found; i++) begin
      cycles(1);
      if (prev == 4'b1000 && pin_control == 4'b0001) found = 1'b1;
      prev = pin_control;
    end
    check("align_frame_found", 32'(found), 32'd1);
  endtask

  initial begin
    cycles(3);
    check("rst_pin_control", 32'(pin_control), 32'd1);
    check("rst_key_code",    32'(key_code),    32'd0);
    check("rst_key_valid",   32'(key_valid),   32'd0);
    check("rst_key_held",    32'(key_held),    32'd0);
    check("rst_multi_key",   32'(multi_key),   32'd0);
    reset = 1'b1;

    // Idle scan
    cycles(3);  check("scan_row0",  32'(pin_control), 32'd1);
    cycles(1);  check("scan_row1",  32'(pin_control), 32'd2);
    cycles(3);  check("scan_row1_hold", 32'(pin_control), 32'd2);
    cycles(1);  check("scan_row2",  32'(pin_control), 32'd4);
    cycles(4);  check("scan_row3",  32'(pin_control), 32'd8);
    cycles(4);  check("scan_wrap",  32'(pin_control), 32'd1);
    cycles(32);
    check("idle_valid_cnt", 32'(valid_cnt), 32'd0);
    check("idle_multi_cnt", 32'(multi_cnt), 32'd0);
    check("idle_key_held",  32'(key_held),  32'd0);

    // Bounce: key 5 visible in one frame only
    align_frame();
    v0 = valid_cnt;
    pressed = 12'd1 << 4;
    cycles(16);
    pressed = '0;
    cycles(48);
    check("bounce_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check("bounce_key_code",  32'(key_code),       32'd0);
    check("bounce_key_held",  32'(key_held),       32'd0);

    // Single press of key 5 for 4 frames
    align_frame();
    v0 = valid_cnt;
    pressed = 12'd1 << 4;
    cycles(20);
    check("single_after_1frame_valid", 32'(valid_cnt - v0), 32'd0);
    cycles(14);
    check("single_after_2frames_valid", 32'(valid_cnt - v0), 32'd1);
    check("single_key_code", 32'(key_code), 32'd5);
    check("single_key_held", 32'(key_held), 32'd1);
    cycles(30);
    check("single_one_pulse", 32'(valid_cnt - v0), 32'd1);
    pressed = '0;
    cycles(20);
    check("release_held_after_1empty", 32'(key_held), 32'd1);
    cycles(16);
    check("release_held_after_2empty", 32'(key_held), 32'd0);
    check("release_code_kept", 32'(key_code), 32'd5);

    // Multi-key: 1 and 3 together for 4 frames
    align_frame();
    v0 = valid_cnt;
    m0 = multi_cnt;
    pressed = 12'b0000_0000_0101;
    cycles(64);
    pressed = '0;
    cycles(16);
    check("multi_pulses",    32'(multi_cnt - m0), 32'd4);
    check("multi_no_valid",  32'(valid_cnt - v0), 32'd0);
    check("multi_code_kept", 32'(key_code),       32'd5);

    // Row 3 map: *, 0, #
    for (int i = 0; i < 3; i++) begin
      align_frame();
      v0 = valid_cnt;
      pressed = 12'd1 << key_idx[i];
      cycles(48);
      check("row3_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      check("row3_key_code",  32'(key_code), 32'(key_code_exp[i]));
      pressed = '0;
      cycles(48);
      check("row3_released", 32'(key_held), 32'd0);
    end

    // Rollover: hold 0, add #, drop 0 without a full release
    align_frame();
    v0 = valid_cnt;
    pressed = 12'd1 << 10;
    cycles(48);
    check("roll_first_valid", 32'(valid_cnt - v0), 32'd1);
    check("roll_first_code",  32'(key_code), 32'd0);
    v0 = valid_cnt;
    m0 = multi_cnt;
    pressed = pressed | (12'd1 << 11);
    cycles(32);
    pressed = 12'd1 << 11;
    cycles(48);
    check("roll_no_second_valid", 32'(valid_cnt - v0), 32'd0);
    check("roll_no_multi",        32'(multi_cnt - m0), 32'd0);
    check("roll_code_kept",       32'(key_code), 32'd0);
    check("roll_still_held",      32'(key_held), 32'd1);
    pressed = '0;
    cycles(48);
    check("roll_released", 32'(key_held), 32'd0);

    // Async reset while key 5 is pressed
    align_frame();
    pressed = 12'd1 << 4;
    cycles(54);
    check("pre_reset_code", 32'(key_code), 32'd5);
    check("pre_reset_held", 32'(key_held), 32'd1);
    check("pre_reset_pin",  32'(pin_control), 32'd2);
    reset = 1'b0;
    #1;
    check("async_rst_pin",   32'(pin_control), 32'd1);
    check("async_rst_code",  32'(key_code),    32'd0);
    check("async_rst_valid", 32'(key_valid),   32'd0);
    check("async_rst_held",  32'(key_held),    32'd0);
    check("async_rst_multi", 32'(multi_key),   32'd0);
    cycles(2);
    reset = 1'b1;
    v0 = valid_cnt;
    cycles(20);
    check("rereport_not_early", 32'(valid_cnt - v0), 32'd0);
    cycles(20);
    check("rereport_valid", 32'(valid_cnt - v0), 32'd1);
    check("rereport_code",  32'(key_code), 32'd5);
    check("rereport_held",  32'(key_held), 32'd1);
    pressed = '0;
    cycles(48);
    check("never_valid_and_multi", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
Upstream stage of keypad_7seg_display. It scans a 4-row x 3-column matrix keypad by driving one row at a time and sensing columns E/F/G. It debounces the scan results over whole frames, rejects multi-key presses, and delivers a 4-bit key code with a one-cycle valid strobe to the display stage. Runs entirely on sys_clk_in.

Parameters:
clk_freq, 28'd1000_0000, system clock frequency in Hz.
scan_rate, 28'd250_0000, row-advance rate in Hz. SCAN_DIV = clk_freq/scan_rate, an integer >= 3 (default 4).
debounce_frames, 2, number of consecutive identical full-frame results required to accept a press or a release (>= 1).

Ports:
sys_clk_in  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
E  input  1  column 0 sense, active-high, asynchronous to clock.
F  input  1  column 1 sense.
G  input  1  column 2 sense.
pin_control  output  4  one-hot row drive, active-high; bit r drives row r.
key_code  output  4  last accepted key code.
key_valid  output  1  one-cycle pulse when key_code is updated.
key_held  output  1  high while an accepted key is still held.
multi_key  output  1  one-cycle pulse when a frame shows more than one key.

Behaviour:
- Reset (async on reset=0):
  - pin_control=4'b0001, row=0, prescaler=0, frame bits cleared, state IDLE, debounce count 0.
  - key_code=0, key_valid=0, key_held=0, multi_key=0.
- Column inputs pass through a 2-flop synchronizer. Synchronizer flops reset to 0.
- Prescaler counts 0..SCAN_DIV-1. tick = (count==SCAN_DIV-1).
- On tick:
  - The synced {G,F,E} is stored into frame slot [row].
  - row advances 0->1->2->3->0 and pin_control = 1<<row.
- The tick at row 3 is frame_done. On frame_done, classify the 12 frame bits (the row-3 sample is included):
  - NONE: 0 bits set.
  - SINGLE(k): exactly 1 bit set.
  - MULTI: 2 or more bits set.
- Key map (row, col E/F/G):
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: 10 (*), 0, 11 (#)
- Debounce FSM (evaluated only on frame_done):
  - IDLE:
    - SINGLE(k): cand=k, cnt=1, go to CONFIRM. If debounce_frames==1, accept immediately.
    - MULTI: pulse multi_key, stay in IDLE.
    - NONE: stay in IDLE.
  - CONFIRM:
    - SINGLE(cand): cnt+1. When cnt reaches debounce_frames, accept.
    - SINGLE(other k) or NONE: go to IDLE, cnt=0.
    - MULTI: pulse multi_key, go to IDLE.
  - Accept: key_code<=cand, pulse key_valid, key_held<=1, go to PRESSED.
  - PRESSED:
    - NONE: go to RELEASE, cnt=1. If debounce_frames==1, go straight to IDLE and clear key_held.
    - Anything else: stay. Rollover is ignored and no multi_key pulse is issued.
  - RELEASE:
    - NONE: cnt+1. At debounce_frames, go to IDLE and set key_held=0.
    - Any key: go back to PRESSED. There is no new report.
- key_valid and multi_key are registered. Each is high for exactly the one cycle after the frame_done edge that decides it. They are never asserted together.
- key_code holds its value across releases and multi-key events. It changes only on accept.
- Latency: at least 2 sys_clk cycles of synchronizer delay plus debounce_frames full frames (4*SCAN_DIV cycles each) from a stable press to key_valid.
- Reset mid-operation: all state clears immediately. A key still held after reset is released is re-debounced and reported again.
- The inputs are level-only, with no edge assumptions. E/F/G glitches shorter than one tick and not aligned to the sample are not seen.

Test Plan:
- Idle scan. Defaults, no keys pressed. Required: pin_control steps 0001->0010->0100->1000->0001, 4 cycles per row. key_valid, key_held and multi_key stay 0.
- Single press. Bench column model is col = OR(pressed & pin_control row). Hold key 5 (row1, F) for 4 frames. Required: exactly one key_valid pulse, key_code=5, key_held=1. After release, key_held falls after 2 empty frames.
- Bounce reject. Key 5 is present for 1 frame only. Required: no key_valid, key_code stays 0, FSM returns to IDLE.
- Multi-key. Keys 1 and 3 (row0, E+G) held together. Required: one multi_key pulse per frame, no key_valid, key_code unchanged.
- Row 3 map and rollover.
  - Press *, release, press 0, release, press #. Required: codes 10, 0, 11 in order.
  - Hold 0, then add # and release 0 without a full release. Required: no second key_valid.
- Async reset mid-press. Drop reset low while PRESSED with key 5. Required: all outputs go to reset values immediately. After reset rises with the key held, key_valid is reported again with key_code=5 after 2 frames.
